regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port between two writeback requesters: port 0 (EXU/CSR result) and port 1 (LSU load data). It applies round-robin arbitration and drives the write port through one register stage. It also keeps a per-register busy scoreboard that the IDU queries for RAW hazards. The block sits between the EXU/LSU writeback outputs and the register file write interface.

Parameters:
ADDR_WIDTH, 5, register index width; the scoreboard has 2**ADDR_WIDTH entries.
DATA_WIDTH, 32, writeback data width.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
wb0_valid  in  1  port 0 write request
wb0_ready  out  1  port 0 accepted this cycle
wb0_addr  in  ADDR_WIDTH  port 0 destination register
wb0_data  in  DATA_WIDTH  port 0 write data
wb1_valid  in  1  port 1 write request
wb1_ready  out  1  port 1 accepted this cycle
wb1_addr  in  ADDR_WIDTH  port 1 destination register
wb1_data  in  DATA_WIDTH  port 1 write data
rf_wen  out  1  register-file write enable (registered)
rf_waddr  out  ADDR_WIDTH  register-file write address (registered)
rf_wdata  out  DATA_WIDTH  register-file write data (registered)
sb_set  in  1  issue marks a destination as pending
sb_set_addr  in  ADDR_WIDTH  register being marked pending
sb_qaddr1  in  ADDR_WIDTH  hazard query address 1
sb_qaddr2  in  ADDR_WIDTH  hazard query address 2
sb_busy1  out  1  sb_qaddr1 has a pending write
sb_busy2  out  1  sb_qaddr2 has a pending write

Behaviour:
- Reset: synchronous, active-high, on the clk rising edge.
  - rf_wen=0, rf_waddr=0, rf_wdata=0.
  - All scoreboard bits=0; sb_busy1/2 read 0.
  - RR pointer last_grant=1, so port 0 wins the first contention.
- Handshake: transfer when valid&&ready at the rising edge. Ready is combinational from the valids and last_grant and never depends on ready.
  - Only wb0_valid high: wb0_ready=1.
  - Only wb1_valid high: wb1_ready=1.
  - Both high: the port != last_grant gets ready=1; the other gets 0.
  - Never both ready in one cycle.
- Requester rule: a requester holding valid=1 with ready=0 keeps addr/data stable until accepted.
- RR update: on any transfer, last_grant <= granted port index. With no transfer, last_grant holds.
- Output stage: fixed 1-cycle latency, always drains, so one write per cycle is sustainable.
  - Transfer at edge N: rf_wen=1 and rf_waddr/rf_wdata = winner's addr/data during cycle N+1; the register file writes at edge N+1.
  - No transfer at edge N: rf_wen=0 in cycle N+1; rf_waddr/rf_wdata hold their previous values.
- x0 handling:
  - A request with addr=0 is accepted normally and advances the RR pointer.
  - rf_wen stays 0 for that slot.
  - sb_set with sb_set_addr=0 is ignored; sb_busy for query address 0 is always 0.
- Scoreboard: one bit per register, updated at the rising edge.
  - sb_set=1 and addr!=0: bit[sb_set_addr] <= 1.
  - rf_wen=1: bit[rf_waddr] <= 0, on the same edge the register file commits.
  - Same register set and cleared on the same edge: set wins, bit stays 1 (newer producer outstanding).
  - Set on an already-busy register: stays 1. The bit tracks only the latest producer; the IDU must not issue a second writer to a busy register.
- Queries: sb_busy1/2 are combinational reads of the current bits. They do not bypass the in-flight rf_wen, so busy drops in the cycle after rf_wen. Register-file read data is valid in that same cycle.
- Reset mid-operation: an accepted but uncommitted write is dropped (rf_wen=0 after reset), and all pending bits are cleared.

Test Plan:
- Reset then idle: assert rst 2 cycles -> rf_wen=0, sb_busy1/2=0 for all query addresses; first contention grants port 0.
- Single port: wb1_valid=1, addr=5, data=0xDEADBEEF at edge N -> wb1_ready=1 in cycle N; rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF in cycle N+1; rf_wen=0 in N+2.
- Contention: both valid every cycle for 4 cycles with port0 addr=1, data=0x11 and port1 addr=2, data=0x22 -> grants 0,1,0,1; rf_waddr sequence 1,2,1,2 on consecutive cycles; stalled port's inputs held.
- Scoreboard life: sb_set addr=7 -> sb_busy1 (qaddr1=7) =1 the next cycle; later a wb0 write to 7 -> busy stays 1 while rf_wen=1, and drops to 0 the cycle after.
- Set/clear collision: rf_wen=1 with rf_waddr=9 and sb_set addr=9 on the same edge -> sb_busy for 9 remains 1.
- x0 and reset: wb0 write to addr 0 -> wb0_ready=1, rf_wen=0, RR pointer advances; sb_set addr=0 -> busy stays 0. Asserting rst the cycle after a transfer -> rf_wen=0 and all busy bits 0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin share of the register-file write port plus a per-register busy scoreboard
module regfile_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb0_valid,
  output logic                  wb0_ready,
  input  logic [ADDR_WIDTH-1:0] wb0_addr,
  input  logic [DATA_WIDTH-1:0] wb0_data,
  input  logic                  wb1_valid,
  output logic                  wb1_ready,
  input  logic [ADDR_WIDTH-1:0] wb1_addr,
  input  logic [DATA_WIDTH-1:0] wb1_data,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic                  sb_set,
  input  logic [ADDR_WIDTH-1:0] sb_set_addr,
  input  logic [ADDR_WIDTH-1:0] sb_qaddr1,
  input  logic [ADDR_WIDTH-1:0] sb_qaddr2,
  output logic                  sb_busy1,
  output logic                  sb_busy2
);
  logic                     last_grant;
  logic [2**ADDR_WIDTH-1:0] sb;
  logic                     xfer;
  logic [ADDR_WIDTH-1:0]    w_addr;
  logic [DATA_WIDTH-1:0]    w_data;
  always_comb begin
    wb0_ready = wb0_valid && (!wb1_valid || last_grant);
    wb1_ready = wb1_valid && (!wb0_valid || !last_grant);
    xfer      = wb0_ready || wb1_ready;
    w_addr    = wb1_ready ? wb1_addr : wb0_addr;
    w_data    = wb1_ready ? wb1_data : wb0_data;
    sb_busy1  = sb[sb_qaddr1];
    sb_busy2  = sb[sb_qaddr2];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen     <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      last_grant <= 1'b1;
      sb         <= '0;
    end else begin
      rf_wen <= xfer && (w_addr != '0);
      if (xfer) begin
        rf_waddr   <= w_addr;
        rf_wdata   <= w_data;
        last_grant <= wb1_ready;
      end
      if (rf_wen) sb[rf_waddr] <= 1'b0;
      // a set issued on the commit edge belongs to a newer producer, so it overrides the clear
      if (sb_set && sb_set_addr != '0) sb[sb_set_addr] <= 1'b1;
    end
  end
endmodule
